// File: rtl/nn_neuron_mac_if.sv
// Handshake and register-write bus of nn_neuron_mac.
// With NN_NEURON_RELU_OUT_EN defined, the bus also carries relu_out.
interface nn_neuron_mac_if #(
  parameter int N_INPUTS = 4,
  parameter int IN_W     = 8,
  parameter int W_W      = 8
);
  localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int ACC_W  = IN_W + W_W + $clog2(N_INPUTS + 1);

  logic                       w_wr_en;
  logic [ADDR_W-1:0]          w_wr_addr;
  logic signed [W_W-1:0]      w_wr_data;
  logic                       bias_wr_en;
  logic signed [W_W-1:0]      bias_wr_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_INPUTS*IN_W-1:0]   x_in;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    acc_out;
  logic                       y_out;
  logic                       busy;
`ifdef NN_NEURON_RELU_OUT_EN
  logic signed [ACC_W-1:0]    relu_out;

  modport master (
    output w_wr_en, w_wr_addr, w_wr_data, bias_wr_en, bias_wr_data,
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, acc_out, y_out, busy, relu_out
  );
  modport slave (
    input  w_wr_en, w_wr_addr, w_wr_data, bias_wr_en, bias_wr_data,
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, acc_out, y_out, busy, relu_out
  );
`else
  modport master (
    output w_wr_en, w_wr_addr, w_wr_data, bias_wr_en, bias_wr_data,
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, acc_out, y_out, busy
  );
  modport slave (
    input  w_wr_en, w_wr_addr, w_wr_data, bias_wr_en, bias_wr_data,
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, acc_out, y_out, busy
  );
`endif
endinterface

// File: rtl/nn_neuron_mac.sv
// Sequential neuron: bias + sum(x[i]*w[i]) through one shared multiplier, step activation.
// Optional feature macro NN_NEURON_RELU_OUT_EN adds a registered relu_out result.
module nn_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int IN_W     = 8,
  parameter int W_W      = 8
) (
  input logic            clk,
  input logic            rst,
  nn_neuron_mac_if.slave bus
);
  localparam int ADDR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int ACC_W  = IN_W + W_W + $clog2(N_INPUTS + 1);
  localparam int PROD_W = IN_W + W_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                  state_q, state_d;
  logic signed [W_W-1:0]   w_q [N_INPUTS];
  logic signed [W_W-1:0]   w_d [N_INPUTS];
  logic signed [W_W-1:0]   bias_q, bias_d;
  logic signed [IN_W-1:0]  x_q [N_INPUTS];
  logic signed [IN_W-1:0]  x_d [N_INPUTS];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    y_q, y_d;
`ifdef NN_NEURON_RELU_OUT_EN
  logic signed [ACC_W-1:0] relu_q, relu_d;
`endif

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_pos;
  logic                     addr_ok;

  assign prod    = PROD_W'(x_q[idx_q]) * PROD_W'(w_q[idx_q]);
  assign acc_sum = acc_q + ACC_W'(prod);
  // Sign-bit test keeps the strict "> 0" threshold free of signed/unsigned compare pitfalls.
  assign acc_pos = !acc_sum[ACC_W-1] && (acc_sum != '0);
  assign addr_ok = {1'b0, bus.w_wr_addr} < (ADDR_W+1)'(N_INPUTS);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    bias_d    = bias_q;
    x_d       = x_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    acc_out_d = acc_out_q;
    y_d       = y_q;
`ifdef NN_NEURON_RELU_OUT_EN
    relu_d    = relu_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.w_wr_en && addr_ok) w_d[bus.w_wr_addr] = bus.w_wr_data;
        if (bus.bias_wr_en)         bias_d = bus.bias_wr_data;
        if (bus.in_valid) begin
          for (int i = 0; i < N_INPUTS; i++) x_d[i] = bus.x_in[i*IN_W +: IN_W];
          // bias_d already reflects a coincident bias write
          acc_d   = ACC_W'(bias_d);
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(N_INPUTS - 1)) begin
          acc_out_d = acc_sum;
          y_d       = acc_pos;
`ifdef NN_NEURON_RELU_OUT_EN
          relu_d    = acc_pos ? acc_sum : '0;
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_q       <= '{default: '0};
      bias_q    <= '0;
      x_q       <= '{default: '0};
      acc_q     <= '0;
      idx_q     <= '0;
      acc_out_q <= '0;
      y_q       <= 1'b0;
`ifdef NN_NEURON_RELU_OUT_EN
      relu_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      bias_q    <= bias_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      acc_out_q <= acc_out_d;
      y_q       <= y_d;
`ifdef NN_NEURON_RELU_OUT_EN
      relu_q    <= relu_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.acc_out   = acc_out_q;
  assign bus.y_out     = y_q;
`ifdef NN_NEURON_RELU_OUT_EN
  assign bus.relu_out  = relu_q;
`endif

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Randomised bench for nn_neuron_mac against an arithmetic reference (weights/bias arrays).
module tb_nn_neuron_mac;
  localparam int N    = 4;
  localparam int IN_W = 8;
  localparam int W_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_neuron_mac_if #(.N_INPUTS(N), .IN_W(IN_W), .W_W(W_W)) bus ();
  nn_neuron_mac #(.N_INPUTS(N), .IN_W(IN_W), .W_W(W_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;
  int w_m [N];
  int b_m;
  int last_acc;
  int xv [N];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All write tasks start just after a negedge and leave just after one.
  task automatic wr_w(input int a, input int v);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = 2'(a);
    bus.w_wr_data = 8'(v);
    @(negedge clk);
    bus.w_wr_en = 1'b0;
    w_m[a] = v;
  endtask

  task automatic wr_b(input int v);
    bus.bias_wr_en   = 1'b1;
    bus.bias_wr_data = 8'(v);
    @(negedge clk);
    bus.bias_wr_en = 1'b0;
    b_m = v;
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    xv[0] = a; xv[1] = b; xv[2] = c; xv[3] = d;
  endtask

  task automatic run_vec(input string tag, input int hold, input bit wr_acc, input bit wr_mac);
    int exp;
    int lat;
    chk({tag, "_rdy"}, longint'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) bus.x_in[i*IN_W +: IN_W] = 8'(xv[i]);
    if (wr_acc) begin
      bus.w_wr_en = 1'b1; bus.w_wr_addr = '0; bus.w_wr_data = 8'sd99;
      w_m[0] = 99;
    end
    exp = b_m;
    for (int i = 0; i < N; i++) exp += xv[i] * w_m[i];
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.w_wr_en  = 1'b0;
    bus.x_in     = 32'($urandom);
    if (wr_mac) begin
      bus.w_wr_en = 1'b1; bus.w_wr_addr = '0; bus.w_wr_data = 8'sd99;
    end
    chk({tag, "_busy"}, longint'(bus.busy), 1);
    chk({tag, "_nrdy"}, longint'(bus.in_ready), 0);
    chk({tag, "_hold_prev"}, longint'(bus.acc_out), last_acc);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      bus.w_wr_en = 1'b0;
      lat++;
    end
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_acc"}, longint'(bus.acc_out), exp);
    chk({tag, "_y"}, longint'(bus.y_out), (exp > 0) ? 1 : 0);
`ifdef NN_NEURON_RELU_OUT_EN
    chk({tag, "_relu"}, longint'(bus.relu_out), (exp > 0) ? exp : 0);
`endif
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        bus.bias_wr_en = 1'b1; bus.bias_wr_data = 8'($urandom);
      end
      @(negedge clk);
      bus.bias_wr_en = 1'b0;
      chk({tag, "_stall_vld"}, longint'(bus.out_valid), 1);
      chk({tag, "_stall_rdy"}, longint'(bus.in_ready), 0);
      chk({tag, "_stall_acc"}, longint'(bus.acc_out), exp);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_post_vld"}, longint'(bus.out_valid), 0);
    chk({tag, "_post_rdy"}, longint'(bus.in_ready), 1);
    chk({tag, "_post_busy"}, longint'(bus.busy), 0);
    chk({tag, "_post_acc"}, longint'(bus.acc_out), exp);
    last_acc = exp;
  endtask

  initial begin
    bus.w_wr_en = 0; bus.w_wr_addr = '0; bus.w_wr_data = '0;
    bus.bias_wr_en = 0; bus.bias_wr_data = '0;
    bus.in_valid = 0; bus.x_in = '0; bus.out_ready = 0;
    for (int i = 0; i < N; i++) w_m[i] = 0;
    b_m = 0; last_acc = 0;
    rst = 1'b1;
    #3;
    chk("rst_vld", longint'(bus.out_valid), 0);
    chk("rst_acc", longint'(bus.acc_out), 0);
    chk("rst_y", longint'(bus.y_out), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_rdy", longint'(bus.in_ready), 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // AND gate, trailing weights left at 0
    wr_w(0, 20); wr_w(1, 20); wr_b(-30);
    set_x(0, 0, 0, 0); run_vec("and00", 0, 0, 0);
    chk("and00_lit", longint'(bus.acc_out), -30);
    set_x(0, 1, 0, 0); run_vec("and01", 0, 0, 0);
    set_x(1, 0, 0, 0); run_vec("and10", 0, 0, 0);
    set_x(1, 1, 0, 0); run_vec("and11", 1, 0, 0);
    chk("and11_lit", longint'(bus.acc_out), 10);

    // strict threshold at exactly zero
    wr_w(0, 10); wr_w(1, 10); wr_b(-20);
    set_x(1, 1, 0, 0); run_vec("zero", 0, 0, 0);
    chk("zero_y_lit", longint'(bus.y_out), 0);

    // extreme operands
    for (int i = 0; i < N; i++) wr_w(i, -128);
    wr_b(127);
    set_x(-128, -128, -128, -128); run_vec("max", 5, 0, 0);
    chk("max_lit", longint'(bus.acc_out), 65663);

    // write during MAC dropped, write coincident with accept used
    set_x(3, -2, 5, 1); run_vec("wr_mac", 0, 0, 1);
    set_x(3, -2, 5, 1); run_vec("wr_acc", 0, 1, 0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) wr_w(i, int'($urandom_range(0, 255)) - 128);
      wr_b(int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      run_vec($sformatf("rnd%0d", t), int'($urandom_range(0, 2)), 0, 0);
    end

    // reset in the middle of MAC
    wr_w(0, 7); wr_b(5);
    set_x(1, 0, 0, 0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) bus.x_in[i*IN_W +: IN_W] = 8'(xv[i]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy_pre", longint'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_vld", longint'(bus.out_valid), 0);
    chk("mid_acc", longint'(bus.acc_out), 0);
    chk("mid_y", longint'(bus.y_out), 0);
    chk("mid_busy", longint'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) w_m[i] = 0;
    b_m = 0; last_acc = 0;
    repeat (6) @(negedge clk);
    chk("mid_no_vld", longint'(bus.out_valid), 0);
    for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(1, 127));
    run_vec("post_rst", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
